csr_unit: RTL and testbench
===========================

# csr_unit

Machine-mode CSR file and trap controller for the pipelined RV32I core. Accepts CSR read addresses from ID and the CSR write triple (`csr_we`, `csr_waddr`, `csr_wdata`) from EX. Holds the trap state (mstatus/mie/mip/mtvec/mepc/mcause/mscratch) and a 64-bit cycle counter. Arbitrates exceptions, external/timer interrupts and `mret` at the commit point, and drives the PC redirect back to IF.

## Interface
- `MTVEC_RESET`, 32'h0000_0100, reset value of mtvec.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `csr_raddr`  in  12  read address from ID.
- `csr_rdata`  out  32  combinational read data for `csr_raddr`.
- `csr_illegal`  out  1  `csr_raddr` is not implemented (combinational).
- `csr_we`  in  1  write strobe from EX; already qualified by EX valid.
- `csr_waddr`  in  12  write address.
- `csr_wdata`  in  32  final write value (OR/ANDN already applied in EX).
- `commit_valid`  in  1  an instruction is at the commit point this cycle.
- `commit_pc`  in  32  PC of that instruction.
- `exc_valid`  in  1  committing instruction raised a synchronous exception.
- `exc_code`  in  5  exception cause code.
- `mret`  in  1  committing instruction is MRET.
- `ext_irq`  in  1  asynchronous external interrupt line.
- `trap_redirect`  out  1  flush the pipeline and fetch from `trap_target` (combinational).
- `trap_target`  out  32  redirect PC.

## Operation
- **Implemented CSRs (addr: fields)**
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] hardwired 2'b11, other bits 0.
  - mie 0x304: MTIE[7], MEIE[11], other bits 0.
  - mtvec 0x305: direct mode only, bits[1:0] read 0.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342.
  - mip 0x344: read-only, MTIP[7], MEIP[11].
  - mcycle 0xB00, mcycleh 0xB80.
  - Unimplemented addresses: read 0, `csr_illegal`=1, writes ignored.
- **Reset values**: mstatus 0x0000_1800, mie 0, mtvec `MTVEC_RESET`, mepc 0, mcause 0, mscratch 0, mcycle 0, synchronizer 0.
- **Interrupt path**
  - `ext_irq` passes through a 2-flop synchronizer; the second flop output is MEIP.
  - Pending interrupt = `mstatus.MIE && ((MEIE && MEIP) || (MTIE && MTIP))`.
- **Event priority per cycle** (all events require `commit_valid`):
  - `exc_valid` first.
  - Pending interrupt second; MEI wins over MTI.
  - `mret` last.
- **Exception**
  - mepc ← `commit_pc`; mcause ← {27'b0, `exc_code`}.
  - MPIE ← MIE, MIE ← 0.
  - target = mtvec.
- **Interrupt**
  - Same mstatus/mepc updates as an exception.
  - mcause = 0x8000_000B for MEI, 0x8000_0007 for MTI.
  - target = mtvec.
- **mret**
  - MIE ← MPIE, MPIE ← 1.
  - target = mepc.
- **`trap_redirect` timing**: asserted the same cycle as the winning event; 0 otherwise. `trap_target` holds mtvec when no event is active.
- **CSR write collisions**
  - A CSR write in a cycle with `trap_redirect`=1 is dropped; the EX instruction is being flushed.
  - Otherwise the write lands at the next edge.
- **mcycle**
  - 64-bit counter, increments every cycle, carry from mcycle into mcycleh.
  - A write to either half replaces that half that cycle (no increment on it).
  - The other half still counts normally, including carry.
- **Reads** return the registered value. A write in cycle N is visible on `csr_rdata` in cycle N+1; no internal forwarding, the ID bypass handles it.

## Timing
- `csr_rdata`, `csr_illegal`, `trap_redirect`, `trap_target`: zero-latency combinational.
- CSR write and trap state update: one edge.
- `ext_irq` rise → MEIP visible: 2 edges. MEIP → redirect: first following cycle with `commit_valid` and enables set.
- Reset asserted mid-trap: all state returns to reset values immediately; redirect deasserts.

## Configuration
- **`CSR_TIMER_EN` defined**
  - Adds 64-bit mtime (0x7C0 low, 0x7C4 high) incrementing every cycle.
  - Adds mtimecmp (0x7C1 low, 0x7C5 high), reset value all-ones.
  - MTIP = (mtime >= mtimecmp), unsigned 64-bit compare.
- **Not defined**
  - Those addresses are unimplemented (read 0, illegal).
  - MTIP = 0; MTIE is hardwired 0.

## Structure
- CSR addresses, mstatus/mie bit positions, interrupt cause constants and `CSR_TIMER_EN` go in the shared `defines.v`.
- One sub-module, `csr_counter64`, is instantiated for mcycle and, when `CSR_TIMER_EN` is defined, for mtime. It has:
  - 64-bit increment;
  - per-half write enable and data;
  - asynchronous active-high reset.

## Test plan
- **Reset read-back**: pulse `rst` → read 0x300 = 0x0000_1800, 0x305 = 0x0000_0100, 0x342 = 0.
- **CSR write**: write 0x340 = 0xDEAD_BEEF in cycle N → `csr_rdata` old value in N, 0xDEAD_BEEF in N+1. Write 0x305 = 0x0000_0203 → reads 0x0000_0200.
- **Exception**: `exc_valid`, `exc_code`=11, `commit_pc`=0x40 with MIE=1 → same cycle redirect to mtvec. Next cycle: mepc = 0x40, mcause = 11, MIE = 0, MPIE = 1. Then `mret` → target 0x40, MIE = 1.
- **External interrupt**: mie = 0x800, MIE = 1, raise `ext_irq` → no redirect for 2 edges, then redirect with mcause 0x8000_000B. Same cycle with `csr_we` → write dropped.
- **Simultaneous events**: `exc_valid` + pending MEI + `mret` in one cycle → exception wins, mcause = `exc_code`.
- **Counter carry and timer**:
  - Write mcycle = 0xFFFF_FFFE → after 2 edges mcycle = 0, mcycleh incremented by 1.
  - With `CSR_TIMER_EN`: mtimecmp = mtime + 5 → MTIP rises 5 edges later.

Source files
------------

// File: rtl/csr_unit_pkg.sv
// Shared CSR addresses, field positions and trap cause constants for csr_unit.
// The optional machine timer is enabled by defining CSR_TIMER_EN at compile time.
package csr_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MTIME     = 12'h7C0;
  localparam logic [11:0] CSR_MTIMEH    = 12'h7C4;
  localparam logic [11:0] CSR_MTIMECMP  = 12'h7C1;
  localparam logic [11:0] CSR_MTIMECMPH = 12'h7C5;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_EXC  = 2'd1,
    EVT_IRQ  = 2'd2,
    EVT_MRET = 2'd3
  } trap_evt_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves; a write
// replaces its half for that edge while the other half keeps counting.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;
  logic [63:0] inc_s;

  // increment with carry, then let a write override its half
  always_comb begin
    inc_s = cnt_q + 64'd1;
    cnt_d = inc_s;
    if (we_lo) begin
      cnt_d[31:0] = wdata;
    end else begin
      cnt_d[31:0] = inc_s[31:0];
    end
    if (we_hi) begin
      cnt_d[63:32] = wdata;
    end else begin
      cnt_d[63:32] = inc_s[63:32];
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 64'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller (exceptions, MEI/MTI, mret).
// Define CSR_TIMER_EN to add mtime/mtimecmp and the machine timer interrupt.
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        csr_we,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        mret,
  input  logic        ext_irq,
  output logic        trap_redirect,
  output logic [31:0] trap_target
);
  import csr_unit_pkg::*;

  logic        sync1_q, sync1_d, meip_q, meip_d;
  logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_meie_q, mie_meie_d;
  logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [63:0] mcycle_s;
  logic        mtip_s, mtie_s, irq_mei_s, irq_mti_s, wr_ok_s;
  logic [31:0] irq_cause_s;
  trap_evt_e   evt_s;

  // pick the single winning commit-point event
  always_comb begin
    irq_mei_s = mstatus_mie_q & mie_meie_q & meip_q;
    irq_mti_s = mstatus_mie_q & mtie_s & mtip_s;
    if (irq_mei_s) begin
      irq_cause_s = CAUSE_MEI;
    end else begin
      irq_cause_s = CAUSE_MTI;
    end
    if (!commit_valid) begin
      evt_s = EVT_NONE;
    end else if (exc_valid) begin
      evt_s = EVT_EXC;
    end else if (irq_mei_s || irq_mti_s) begin
      evt_s = EVT_IRQ;
    end else if (mret) begin
      evt_s = EVT_MRET;
    end else begin
      evt_s = EVT_NONE;
    end
  end

  // EX is flushed on any redirect, so its write must not land
  assign wr_ok_s       = csr_we & (evt_s == EVT_NONE);
  assign trap_redirect = (evt_s != EVT_NONE) & ~rst;
  assign trap_target   = (evt_s == EVT_MRET) ? mepc_q : mtvec_q;

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .we_lo (wr_ok_s & (csr_waddr == CSR_MCYCLE)),
    .we_hi (wr_ok_s & (csr_waddr == CSR_MCYCLEH)),
    .wdata (csr_wdata),
    .value (mcycle_s)
  );

`ifdef CSR_TIMER_EN
  logic [63:0] mtime_s, mtimecmp_q, mtimecmp_d;
  logic        mie_mtie_q, mie_mtie_d;

  csr_counter64 u_mtime (
    .clk   (clk),
    .rst   (rst),
    .we_lo (wr_ok_s & (csr_waddr == CSR_MTIME)),
    .we_hi (wr_ok_s & (csr_waddr == CSR_MTIMEH)),
    .wdata (csr_wdata),
    .value (mtime_s)
  );

  // timer compare and MTIE write decode
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    mie_mtie_d = mie_mtie_q;
    if (wr_ok_s) begin
      case (csr_waddr)
        CSR_MTIMECMP:  mtimecmp_d[31:0]  = csr_wdata;
        CSR_MTIMECMPH: mtimecmp_d[63:32] = csr_wdata;
        CSR_MIE:       mie_mtie_d        = csr_wdata[MIE_MTIE];
        default:       mtimecmp_d        = mtimecmp_q;
      endcase
    end else begin
      mtimecmp_d = mtimecmp_q;
    end
  end

  // timer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mie_mtie_q <= 1'b0;
    end else begin
      mtimecmp_q <= mtimecmp_d;
      mie_mtie_q <= mie_mtie_d;
    end
  end

  assign mtip_s = (mtime_s >= mtimecmp_q);
  assign mtie_s = mie_mtie_q;
`else
  assign mtip_s = 1'b0;
  assign mtie_s = 1'b0;
`endif

  // trap state update takes precedence; CSR writes only in event-free cycles
  always_comb begin
    sync1_d        = ext_irq;
    meip_d         = sync1_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mscratch_d     = mscratch_q;
    case (evt_s)
      EVT_EXC, EVT_IRQ: begin
        mepc_d = commit_pc & ADDR_MASK;
        if (evt_s == EVT_EXC) begin
          mcause_d = {27'd0, exc_code};
        end else begin
          mcause_d = irq_cause_s;
        end
        mstatus_mpie_d = mstatus_mie_q;
        mstatus_mie_d  = 1'b0;
      end
      EVT_MRET: begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end
      default: begin
        if (csr_we) begin
          case (csr_waddr)
            CSR_MSTATUS: begin
              mstatus_mie_d  = csr_wdata[MSTATUS_MIE];
              mstatus_mpie_d = csr_wdata[MSTATUS_MPIE];
            end
            CSR_MIE:      mie_meie_d = csr_wdata[MIE_MEIE];
            CSR_MTVEC:    mtvec_d    = csr_wdata & ADDR_MASK;
            CSR_MSCRATCH: mscratch_d = csr_wdata;
            CSR_MEPC:     mepc_d     = csr_wdata & ADDR_MASK;
            CSR_MCAUSE:   mcause_d   = csr_wdata;
            default:      mscratch_d = mscratch_q;
          endcase
        end else begin
          mscratch_d = mscratch_q;
        end
      end
    endcase
  end

  // trap state and synchronizer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= 1'b0;
      meip_q         <= 1'b0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET & ADDR_MASK;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mscratch_q     <= 32'd0;
    end else begin
      sync1_q        <= sync1_d;
      meip_q         <= meip_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mscratch_q     <= mscratch_d;
    end
  end

  // registered-value read mux
  always_comb begin
    csr_rdata   = 32'd0;
    csr_illegal = 1'b0;
    case (csr_raddr)
      CSR_MSTATUS:   csr_rdata = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      CSR_MIE:       csr_rdata = {20'd0, mie_meie_q, 3'd0, mtie_s, 7'd0};
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MIP:       csr_rdata = {20'd0, meip_q, 3'd0, mtip_s, 7'd0};
      CSR_MCYCLE:    csr_rdata = mcycle_s[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle_s[63:32];
`ifdef CSR_TIMER_EN
      CSR_MTIME:     csr_rdata = mtime_s[31:0];
      CSR_MTIMEH:    csr_rdata = mtime_s[63:32];
      CSR_MTIMECMP:  csr_rdata = mtimecmp_q[31:0];
      CSR_MTIMECMPH: csr_rdata = mtimecmp_q[63:32];
`endif
      default: begin
        csr_rdata   = 32'd0;
        csr_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios followed by random
// traffic, all compared against an architectural model of the CSR file.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_raddr = 12'h300;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        csr_we = 1'b0;
  logic [11:0] csr_waddr = 12'h000;
  logic [31:0] csr_wdata = 32'd0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = 32'd0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic        mret = 1'b0;
  logic        ext_irq = 1'b0;
  logic        trap_redirect;
  logic [31:0] trap_target;

  always #5 clk = ~clk;

  csr_unit dut (
    .clk(clk), .rst(rst), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .exc_valid(exc_valid), .exc_code(exc_code), .mret(mret), .ext_irq(ext_irq),
    .trap_redirect(trap_redirect), .trap_target(trap_target)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // architectural model
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mscratch;
  logic [63:0] m_cycle;
  logic        m_s1, m_s2;
`ifdef CSR_TIMER_EN
  logic [63:0] m_mtime, m_mtimecmp;
  localparam logic [31:0] MIE_MASK = 32'h0000_0880;
`else
  localparam logic [31:0] MIE_MASK = 32'h0000_0800;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_mtip();
`ifdef CSR_TIMER_EN
    return m_mtime >= m_mtimecmp;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_mstatus = 32'h0000_1800; m_mie = 32'd0; m_mtvec = 32'h0000_0100;
    m_mepc = 32'd0; m_mcause = 32'd0; m_mscratch = 32'd0; m_cycle = 64'd0;
    m_s1 = 1'b0; m_s2 = 1'b0;
`ifdef CSR_TIMER_EN
    m_mtime = 64'd0; m_mtimecmp = '1;
`endif
  endtask

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic il);
    il = 1'b0;
    case (a)
      12'h300: d = m_mstatus;
      12'h304: d = m_mie;
      12'h305: d = m_mtvec;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'h344: d = {20'd0, m_s2, 3'd0, m_mtip(), 7'd0};
      12'hB00: d = m_cycle[31:0];
      12'hB80: d = m_cycle[63:32];
`ifdef CSR_TIMER_EN
      12'h7C0: d = m_mtime[31:0];
      12'h7C4: d = m_mtime[63:32];
      12'h7C1: d = m_mtimecmp[31:0];
      12'h7C5: d = m_mtimecmp[63:32];
`endif
      default: begin d = 32'd0; il = 1'b1; end
    endcase
  endtask

  // kind: 0 none, 1 exception, 2 interrupt, 3 mret
  task automatic predict(output int kind, output logic mei);
    logic mti;
    mei = m_mstatus[3] && m_mie[11] && m_s2;
    mti = m_mstatus[3] && m_mie[7] && m_mtip();
    if (!commit_valid) kind = 0;
    else if (exc_valid) kind = 1;
    else if (mei || mti) kind = 2;
    else if (mret) kind = 3;
    else kind = 0;
  endtask

  task automatic update();
    int k; logic mei; logic [63:0] nc;
    predict(k, mei);
    nc = m_cycle + 64'd1;
`ifdef CSR_TIMER_EN
    m_mtime = m_mtime + 64'd1;
`endif
    if (k == 1 || k == 2) begin
      m_mepc = commit_pc & 32'hFFFF_FFFC;
      m_mcause = (k == 1) ? {27'd0, exc_code} : (mei ? 32'h8000_000B : 32'h8000_0007);
      m_mstatus[7] = m_mstatus[3];
      m_mstatus[3] = 1'b0;
    end else if (k == 3) begin
      m_mstatus[3] = m_mstatus[7];
      m_mstatus[7] = 1'b1;
    end else if (csr_we) begin
      case (csr_waddr)
        12'h300: m_mstatus = (csr_wdata & 32'h88) | 32'h1800;
        12'h304: m_mie = csr_wdata & MIE_MASK;
        12'h305: m_mtvec = csr_wdata & 32'hFFFF_FFFC;
        12'h340: m_mscratch = csr_wdata;
        12'h341: m_mepc = csr_wdata & 32'hFFFF_FFFC;
        12'h342: m_mcause = csr_wdata;
        12'hB00: nc[31:0] = csr_wdata;
        12'hB80: nc[63:32] = csr_wdata;
`ifdef CSR_TIMER_EN
        12'h7C1: m_mtimecmp[31:0] = csr_wdata;
        12'h7C5: m_mtimecmp[63:32] = csr_wdata;
`endif
        default: ;
      endcase
    end
    m_cycle = nc;
    m_s2 = m_s1;
    m_s1 = ext_irq;
  endtask

  // compare all combinational outputs mid-cycle, then advance one edge
  task automatic tick();
    int k; logic mei; logic [31:0] d; logic il;
    @(negedge clk);
    predict(k, mei);
    model_read(csr_raddr, d, il);
    check("redirect", {31'd0, trap_redirect}, {31'd0, (k != 0)});
    check("target", trap_target, (k == 3) ? m_mepc : m_mtvec);
    check("rdata", csr_rdata, d);
    check("illegal", {31'd0, csr_illegal}, {31'd0, il});
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_raddr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic idle();
    csr_we = 1'b0; commit_valid = 1'b0; exc_valid = 1'b0; mret = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    ext_irq = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    update();
    #1;
  endtask

  logic [11:0] waddrs [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                               12'h342, 12'h344, 12'hB00, 12'hB80, 12'h123};
  logic [11:0] raddrs [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'h7C5, 12'hFFF};
  logic [31:0] hb;

  initial begin
    model_reset();
    do_reset();
    // reset read-back
    peek("rst_mstatus", 12'h300, 32'h0000_1800);
    peek("rst_mtvec", 12'h305, 32'h0000_0100);
    peek("rst_mcause", 12'h342, 32'h0000_0000);
    // CSR write visible next cycle; mtvec low bits forced to 0
    csr_raddr = 12'h340; csr_we = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'hDEAD_BEEF;
    tick();
    csr_we = 1'b0;
    peek("mscratch_wr", 12'h340, 32'hDEAD_BEEF);
    csr_we = 1'b1; csr_waddr = 12'h305; csr_wdata = 32'h0000_0203;
    tick();
    csr_we = 1'b0;
    peek("mtvec_wr", 12'h305, 32'h0000_0200);
    // exception then mret
    csr_we = 1'b1; csr_waddr = 12'h300; csr_wdata = 32'h0000_0008;
    tick();
    csr_we = 1'b0; commit_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd11; commit_pc = 32'h40;
    #1;
    check("exc_redirect", {31'd0, trap_redirect}, 32'd1);
    check("exc_target", trap_target, 32'h0000_0200);
    tick();
    idle();
    peek("exc_mepc", 12'h341, 32'h0000_0040);
    peek("exc_mcause", 12'h342, 32'd11);
    peek("exc_mstatus", 12'h300, 32'h0000_1880);
    tick();
    commit_valid = 1'b1; mret = 1'b1;
    #1;
    check("mret_target", trap_target, 32'h0000_0040);
    tick();
    idle();
    peek("mret_mstatus", 12'h300, 32'h0000_1888);
    // external interrupt through the synchronizer; colliding write dropped
    csr_we = 1'b1; csr_waddr = 12'h304; csr_wdata = 32'h0000_0800;
    tick();
    idle();
    ext_irq = 1'b1; commit_valid = 1'b1;
    tick();
    check("irq_sync_edge1", {31'd0, trap_redirect}, 32'd0);
    tick();
    check("irq_taken", {31'd0, trap_redirect}, 32'd1);
    csr_we = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'h1234_5678;
    tick();
    idle();
    peek("irq_mcause", 12'h342, 32'h8000_000B);
    peek("irq_wr_dropped", 12'h340, 32'hDEAD_BEEF);
    peek("irq_mstatus", 12'h300, 32'h0000_1880);
    // simultaneous exception + pending MEI + mret
    tick();
    csr_we = 1'b1; csr_waddr = 12'h300; csr_wdata = 32'h0000_0008;
    tick();
    csr_we = 1'b0; commit_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd5; mret = 1'b1;
    commit_pc = 32'h80;
    #1;
    check("simul_target", trap_target, 32'h0000_0200);
    tick();
    idle();
    peek("simul_mcause", 12'h342, 32'd5);
    peek("simul_mepc", 12'h341, 32'h0000_0080);
    // reset asserted while a trap is being redirected
    tick();
    ext_irq = 1'b0; commit_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd2;
    #1;
    check("midtrap_redirect", {31'd0, trap_redirect}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_redirect", {31'd0, trap_redirect}, 32'd0);
    peek("rst_async_mtvec", 12'h305, 32'h0000_0100);
    do_reset();
    // mcycle low-half carry into high half
    csr_we = 1'b1; csr_waddr = 12'hB00; csr_wdata = 32'hFFFF_FFFE;
    hb = m_cycle[63:32];
    tick();
    csr_we = 1'b0;
    tick();
    tick();
    peek("mcycle_wrap", 12'hB00, 32'd0);
    peek("mcycleh_carry", 12'hB80, hb + 32'd1);
    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      csr_we       = ($urandom_range(0, 9) < 3);
      csr_waddr    = waddrs[$urandom_range(0, 9)];
      csr_wdata    = $urandom;
      csr_raddr    = raddrs[$urandom_range(0, 11)];
      commit_valid = $urandom_range(0, 1) == 1;
      exc_valid    = ($urandom_range(0, 9) < 2);
      exc_code     = 5'($urandom);
      mret         = ($urandom_range(0, 9) < 2);
      commit_pc    = $urandom;
      if ($urandom_range(0, 9) == 0) ext_irq = ~ext_irq;
      tick();
    end
`ifdef CSR_TIMER_EN
    // mtimecmp = mtime + 5 -> MTIP rises 5 edges later
    idle();
    ext_irq = 1'b0;
    csr_raddr = 12'h344;
    csr_we = 1'b1; csr_waddr = 12'h7C5; csr_wdata = m_mtime[63:32];
    tick();
    csr_waddr = 12'h7C1; csr_wdata = m_mtime[31:0] + 32'd5;
    tick();
    csr_we = 1'b0;
    tick();
    tick();
    tick();
    check("mtip_edge4", {31'd0, csr_rdata[7]}, 32'd0);
    tick();
    check("mtip_edge5", {31'd0, csr_rdata[7]}, 32'd1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
